// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse configuration link: field widths,
// byte count and the SPI configuration master state encoding.
package pulse_pkg;

    localparam int HIGH_W     = 24;
    localparam int LOW_W      = 40;
    localparam int CONF_W     = 64;
    localparam int CONF_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_BYTE_GAP,
        ST_CS_HOLD,
        ST_DONE
    } spi_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 byte serializer: SCLK high CLK_DIV cycles then low CLK_DIV
// cycles per bit, MSB first, MOSI advancing on each falling edge.
// Ports: i_clk, i_reset (sync, active-low), i_load/i_byte start a byte,
//   i_next_msb is shifted in behind the byte so MOSI already shows the
//   following byte's MSB once the last bit has fallen;
//   o_spi_clk, o_mosi, o_byte_done (1-cycle, last low phase ending).
module spi_byte_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_next_msb,
    output logic       o_spi_clk,
    output logic       o_mosi,
    output logic       o_byte_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_sr;
    logic          r_active;
    logic          r_sclk;
    logic          w_tick;

    assign w_tick      = r_active && (r_cnt == CNT_LAST);
    assign o_byte_done = w_tick && !r_sclk && (r_bit == 3'd7);
    assign o_spi_clk   = r_sclk;
    assign o_mosi      = r_sr[7];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_sr     <= '0;
            r_active <= 1'b0;
            r_sclk   <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_sr     <= i_byte;
            r_active <= 1'b1;
            r_sclk   <= 1'b1;
        end else if (r_active) begin
            if (w_tick) begin
                r_cnt <= '0;
                if (r_sclk) begin
                    r_sclk <= 1'b0;
                    r_sr   <= {r_sr[6:0], i_next_msb};
                end else if (r_bit == 3'd7) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit  <= r_bit + 3'd1;
                    r_sclk <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_conf_master.sv
// SPI master sending the 64-bit pulse word {high, low} as 8 bytes, MSB first.
// Ports: i_clk, i_reset (sync, active-low), i_start, i_high_time[23:0],
//   i_low_time[39:0]; o_busy, o_done, o_spi_clk, o_spi_nCS, o_spi_mosi.
// Option macro SPI_CONF_CS_PER_BYTE_EN: nCS released in every byte gap.
module spi_conf_master
    import pulse_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int GAP_CYCLES = 16,
    parameter int CS_HOLD    = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [HIGH_W-1:0] i_high_time,
    input  logic [LOW_W-1:0]  i_low_time,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_spi_clk,
    output logic              o_spi_nCS,
    output logic              o_spi_mosi
);

    localparam int TMAX = max3(CS_SETUP, GAP_CYCLES, CS_HOLD);
    localparam int TW   = $clog2(TMAX + 1);

    spi_state_t        r_state;
    spi_state_t        w_next;
    logic [CONF_W-1:0] r_word;
    logic [2:0]        r_byte;
    logic [TW-1:0]     r_tcnt;
    logic              r_done;
    logic              w_load;
    logic              w_byte_done;
    logic              w_sh_mosi;
    logic              w_gap_cs;

    spi_byte_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_byte     (r_word[CONF_W-1 -: 8]),
        .i_next_msb (r_word[CONF_W-1]),
        .o_spi_clk  (o_spi_clk),
        .o_mosi     (w_sh_mosi),
        .o_byte_done(w_byte_done)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // w_load fires on the same edge the FSM enters SHIFT, so the first
    // SCLK rise lands exactly CS_SETUP / GAP_CYCLES after the wait began.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = ST_CS_SETUP;
            end
            ST_CS_SETUP: begin
                if (r_tcnt == TW'(CS_SETUP - 1)) begin
                    w_next = ST_SHIFT;
                    w_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_byte_done)
                    w_next = (r_byte == 3'd7) ? ST_CS_HOLD : ST_BYTE_GAP;
            end
            ST_BYTE_GAP: begin
                if (r_tcnt == TW'(GAP_CYCLES - 1)) begin
`ifdef SPI_CONF_CS_PER_BYTE_EN
                    w_next = ST_CS_SETUP;
`else
                    w_next = ST_SHIFT;
                    w_load = 1'b1;
`endif
                end
            end
            ST_CS_HOLD: begin
                if (r_tcnt == TW'(CS_HOLD - 1)) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // The word register shifts a byte out as each byte is loaded, so its
    // MSB is always the next byte's first bit.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_word <= '0;
            r_byte <= '0;
            r_tcnt <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_next != r_state || r_state == ST_IDLE) r_tcnt <= '0;
            else                                          r_tcnt <= r_tcnt + 1'b1;
            r_done <= (r_state == ST_DONE);
            if (r_state == ST_IDLE && i_start)
                r_word <= {i_high_time, i_low_time};
            else if (w_load)
                r_word <= {r_word[CONF_W-9:0], 8'h00};
            if (w_byte_done) r_byte <= r_byte + 3'd1;
        end
    end

`ifdef SPI_CONF_CS_PER_BYTE_EN
    assign w_gap_cs = (r_state == ST_BYTE_GAP);
`else
    assign w_gap_cs = 1'b0;
`endif

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_spi_nCS  = (r_state == ST_IDLE) || (r_state == ST_DONE) || w_gap_cs;
    assign o_spi_mosi = (r_state == ST_CS_SETUP || r_state == ST_BYTE_GAP)
                        ? r_word[CONF_W-1] : w_sh_mosi;

endmodule

// File: tb/tb_spi_conf_master.sv
// Directed bench for spi_conf_master: a model slave captures bytes on
// SCLK rise; latency, framing, restart-ignore and abort are checked.
module tb_spi_conf_master;

`ifdef SPI_CONF_CS_PER_BYTE_EN
    localparam int LAT       = 644;
    localparam int NCS_RISES = 8;
`else
    localparam int LAT       = 630;
    localparam int NCS_RISES = 1;
`endif
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] hi = '0;
    logic [39:0] lo = '0;
    logic        busy, done, sclk, ncs, mosi;

    int n_cmp = 0;
    int n_bad = 0;

    spi_conf_master dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_start    (start),
        .i_high_time(hi),
        .i_low_time (lo),
        .o_busy     (busy),
        .o_done     (done),
        .o_spi_clk  (sclk),
        .o_spi_nCS  (ncs),
        .o_spi_mosi (mosi)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // model slave
    logic       mon_clr = 1'b0;
    logic       prev_sclk = 1'b0;
    logic       prev_ncs = 1'b1;
    logic [7:0] sh = '0;
    logic [7:0] bytes [16];
    int         nbit = 0, nbyte = 0, ndone = 0, ncs_rise = 0;
    int         rise1 = 0, rise2 = 0, cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_clr) begin
            nbit = 0; nbyte = 0; ndone = 0; ncs_rise = 0;
            rise1 = 0; rise2 = 0;
        end else begin
            if (ncs) begin
                nbit = 0;
            end else if (sclk && !prev_sclk) begin
                if (nbyte == 0 && nbit == 0) rise1 = cyc;
                if (nbyte == 0 && nbit == 1) rise2 = cyc;
                sh = {sh[6:0], mosi};
                nbit++;
                if (nbit == 8) begin
                    if (nbyte < 16) bytes[nbyte] = sh;
                    nbyte++;
                    nbit = 0;
                end
            end
            if (ncs && !prev_ncs) ncs_rise++;
            if (done) ndone++;
        end
        prev_sclk = sclk;
        prev_ncs  = ncs;
    end

    function automatic logic [63:0] captured();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w = {w[55:0], bytes[i]};
        return w;
    endfunction

    task automatic send(input logic [23:0] h, input logic [39:0] l,
                        input int restart_at, output int lat);
        int n;
        @(negedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0;
        hi = h; lo = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hi = ~h; lo = ~l;
        n = 1;
        while (!done && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
            start = (n == restart_at);
        end
        start = 1'b0;
        lat = n;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic check_xfer(input string tag, input logic [63:0] exp, input int lat);
        check({tag, "_word"}, captured(), exp);
        check({tag, "_nbytes"}, 64'(nbyte), 64'd8);
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_ndone"}, 64'(ndone), 64'd1);
        check({tag, "_ncs_rise"}, 64'(ncs_rise), 64'(NCS_RISES));
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        for (int i = 0; i < 16; i++) bytes[i] = '0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ncs", 64'(ncs), 64'd1);
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_mosi", 64'(mosi), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        send(24'h000032, 40'h00000000C8, -1, lat);
        check_xfer("v1", 64'h00003200000000C8, lat);
        check("v1_sclk_period", 64'(rise2 - rise1), 64'd8);

        send(24'hA5C37E, 40'h8100FF5A3C, -1, lat);
        check_xfer("v2", 64'hA5C37E8100FF5A3C, lat);

        send(24'hFFFFFF, 40'h0123456789, 250, lat);
        check_xfer("restart", 64'hFFFFFF0123456789, lat);

        // abort in the middle of byte 4
        @(negedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0;
        hi = 24'h5A5A5A; lo = 40'hC3C3C3C3C3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1;
        while (n < 345 && !done) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_ncs", 64'(ncs), 64'd1);
        check("abort_sclk", 64'(sclk), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_mosi", 64'(mosi), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        send(24'h123456, 40'h789ABCDEF0, -1, lat);
        check_xfer("after_abort", 64'h123456789ABCDEF0, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
